sensor_record_writer: RTL
=========================

// Module: sensor_record_writer
// PURPOSE
// - Write-side producer for the nose classifier's sensor memories: accepts tagged 32-bit samples
//   (Temperature, Humidity, Pressure, VCO), assembles complete 4-channel records and commits each
//   record to one index of four DEPTH-entry banks.
// - Exposes a registered read port returning all four channels at one index, plus a record-ready
//   pulse that the decision FSM uses as its start source.
// PARAMETERS
// - WIDTH  32   sample width, signed fixed point, passed through unmodified
// - DEPTH  600  records per bank
// - AW     10   address width, clog2(DEPTH)
// - WRAP   1    1: overwrite oldest record when full; 0: stall input when full
// PORTS
// - clk       in   1      single clock, all logic rising-edge
// - rst       in   1      asynchronous, active-low reset
// - clr       in   1      synchronous clear of pointer/count/staging; bank contents untouched
// - s_valid   in   1      sample valid
// - s_ready   out  1      sample accepted when s_valid && s_ready
// - s_chan    in   2      0=Temperature 1=Humidity 2=Pressure 3=VCO
// - s_data    in   WIDTH  sample value
// - rd_addr   in   AW     read index
// - rd_t/rd_h/rd_p/rd_v out WIDTH  bank contents at rd_addr, 1-cycle latency
// - rec_valid out  1      1-cycle pulse on record commit
// - rec_addr  out  AW     index just committed, valid with rec_valid
// - count     out  AW+1   stored records, saturates at DEPTH
// - full      out  1      count==DEPTH
// - dup_err   out  1      sticky: a channel arrived twice within one record; cleared by clr/reset
// BEHAVIOUR
// - Reset (rst=0, async): s_ready=0, rec_valid=0, rec_addr=0, count=0, full=0, dup_err=0,
//   rd_*=0, wr_ptr=0, staging mask=0, state=IDLE. First cycle after release: s_ready=1.
// - FSM: IDLE (mask==0) -> COLLECT on first accept; COLLECT -> COMMIT when accept makes mask==4'hF;
//   COMMIT -> IDLE after one cycle. s_ready=0 in COMMIT, and when full && WRAP==0.
// - Accept stores s_data in staging[s_chan], sets mask bit. Channel order free.
// - Duplicate channel while its mask bit set: newer value overwrites staging, dup_err<=1.
// - COMMIT: write 4 staged words to banks at wr_ptr in the same cycle; rec_valid=1, rec_addr=wr_ptr;
//   wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1; count <= min(count+1, DEPTH); mask<=0.
// - Full, WRAP=1: commit overwrites oldest index, count stays DEPTH. WRAP=0: s_ready held 0
//   until clr; no partial record is lost (staging kept).
// - Record latency: last sample accept at cycle N -> rec_valid at N+1 -> rd_* at new index
//   readable with rd_addr presented at N+2, data at N+3.
// - Read: rd_* registered; rd_addr >= DEPTH returns 0 on all four. Read of index being written
//   in the same cycle returns old contents (read-before-write).
// - clr: takes priority over accept/commit; wr_ptr=0, count=0, full=0, mask=0, dup_err=0,
//   state=IDLE, rec_valid=0 that cycle. Reset mid-record discards staging.
// - No arithmetic beyond pointer/count; data never resized.
// STRUCTURE
// - Package nose_pkg: WIDTH, DEPTH, AW, channel constants CH_TEMP/CH_HUM/CH_PRES/CH_VCO,
//   state encodings IDLE/COLLECT/COMMIT.
// - Sub-module sensor_bank_ram (1 write, 1 registered read, read-before-write), instantiated 4x.
// - Top holds FSM, staging registers, mask, pointer/count logic.
// TESTING
// - Reset: rst=0 mid-record -> all outputs 0, s_ready=0; release -> s_ready=1 next cycle, count=0.
// - Record: chans 3,0,2,1 with 0x11,0x22,0x33,0x44 -> rec_valid once, rec_addr=0, count=1;
//   rd_addr=0 -> rd_t=0x22 rd_h=0x44 rd_p=0x33 rd_v=0x11 one cycle later.
// - Duplicate: chan0=0x5 then chan0=0x6 then 1,2,3 -> dup_err=1, rd_t=0x6, one commit.
// - Wrap (WRAP=1): 601 records -> rec_addr sequence 0..599,0; count=600, full=1; index 0 holds record 601.
// - Stall (WRAP=0): 600 records -> full=1, s_ready=0; clr -> s_ready=1, count=0, rec_addr restarts 0.
// - Read edge: rd_addr=600 -> rd_*=0; rd_addr=wr index during COMMIT -> returns old data.

Source files
------------

// File: rtl/nose_pkg.sv
// ============================================================================
// nose_pkg : shared constants for the nose sensor record writer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nose_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 600;
  localparam int AW    = 10;

  localparam logic [1:0] CH_TEMP = 2'd0;
  localparam logic [1:0] CH_HUM  = 2'd1;
  localparam logic [1:0] CH_PRES = 2'd2;
  localparam logic [1:0] CH_VCO  = 2'd3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  function automatic logic [3:0] chan_bit(input logic [1:0] chan);
    return 4'b0001 << chan;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_bank_ram.sv
// ============================================================================
// sensor_bank_ram : one-write / one-registered-read bank, read-before-write
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_bank_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 600,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Addresses past the last record read as zero rather than aliasing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_addr <= LAST_ADDR) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sensor_record_writer.sv
// ============================================================================
// sensor_record_writer : assembles tagged samples into 4-channel records and
//                        commits each record to one index of four banks
// Revision             : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_record_writer
  import nose_pkg::*;
#(
  parameter int WIDTH = nose_pkg::WIDTH,
  parameter int DEPTH = nose_pkg::DEPTH,
  parameter int AW    = nose_pkg::AW,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_chan,
  input  logic [WIDTH-1:0] s_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_t,
  output logic [WIDTH-1:0] rd_h,
  output logic [WIDTH-1:0] rd_p,
  output logic [WIDTH-1:0] rd_v,
  output logic             rec_valid,
  output logic [AW-1:0]    rec_addr,
  output logic [AW:0]      count,
  output logic             full,
  output logic             dup_err
);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam bit            STALL_FULL = !WRAP;

  logic [1:0]       state;
  logic [3:0]       mask;
  logic [WIDTH-1:0] stage [4];
  logic [AW-1:0]    wr_ptr;
  logic             running;
  logic             accept;
  logic             commit_we;
  logic [3:0]       chan_sel;
  logic [3:0]       mask_next;

  assign full      = (count == FULL_COUNT);
  assign s_ready   = running && (state != COMMIT) && !(STALL_FULL && full);
  assign accept    = s_valid && s_ready;
  assign commit_we = (state == COMMIT) && !clr;
  assign rec_valid = commit_we;
  assign rec_addr  = wr_ptr;
  assign chan_sel  = chan_bit(s_chan);
  assign mask_next = mask | chan_sel;

  // Holds s_ready low for the whole reset and releases it one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mask    <= 4'h0;
      wr_ptr  <= '0;
      count   <= '0;
      dup_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stage[i] <= '0;
      end
    end else if (clr) begin
      state   <= IDLE;
      mask    <= 4'h0;
      wr_ptr  <= '0;
      count   <= '0;
      dup_err <= 1'b0;
    end else if (state == COMMIT) begin
      state  <= IDLE;
      mask   <= 4'h0;
      wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
      if (!full) begin
        count <= count + 1'b1;
      end
    end else if (accept) begin
      stage[s_chan] <= s_data;
      mask          <= mask_next;
      if ((mask & chan_sel) != 4'h0) begin
        dup_err <= 1'b1;
      end
      state <= (mask_next == 4'hF) ? COMMIT : COLLECT;
    end
  end

  sensor_bank_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank_t (
    .clk(clk), .rst(rst), .we(commit_we), .wr_addr(wr_ptr),
    .wr_data(stage[CH_TEMP]), .rd_addr(rd_addr), .rd_data(rd_t)
  );

  sensor_bank_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank_h (
    .clk(clk), .rst(rst), .we(commit_we), .wr_addr(wr_ptr),
    .wr_data(stage[CH_HUM]), .rd_addr(rd_addr), .rd_data(rd_h)
  );

  sensor_bank_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank_p (
    .clk(clk), .rst(rst), .we(commit_we), .wr_addr(wr_ptr),
    .wr_data(stage[CH_PRES]), .rd_addr(rd_addr), .rd_data(rd_p)
  );

  sensor_bank_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank_v (
    .clk(clk), .rst(rst), .we(commit_we), .wr_addr(wr_ptr),
    .wr_data(stage[CH_VCO]), .rd_addr(rd_addr), .rd_data(rd_v)
  );

endmodule

`default_nettype wire
